// File: rtl/score_bcd_display_if.sv
// Score-to-display bus: binary score in, registered BCD digits, segment
// patterns and status out. The display block sits on the slave modport.
interface score_bcd_display_if #(
  parameter int SCORE_W = 7
);
  logic [SCORE_W-1:0] score;
  logic [3:0]         tens_bcd;
  logic [3:0]         ones_bcd;
  logic [6:0]         seg_tens;
  logic [6:0]         seg_ones;
  logic               busy;
  logic               sat;

  modport master (
    output score,
    input  tens_bcd, ones_bcd, seg_tens, seg_ones, busy, sat
  );

  modport slave (
    input  score,
    output tens_bcd, ones_bcd, seg_tens, seg_ones, busy, sat
  );
endinterface

// File: rtl/score_bcd_display.sv
// score_bcd_display: samples a foreign-domain binary score, qualifies it
// for stability and converts it to two BCD digits with an iterative
// shift-add-3 engine. Display registers only load on completed conversions.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is 0.
module score_bcd_display #(
  parameter int SCORE_W    = 7,
  parameter int MAX_SHOWN  = 99,
  parameter int CONV_STEPS = 7
) (
  input  logic                clk,
  input  logic                rst,
  score_bcd_display_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

  localparam int                 STEP_W     = (CONV_STEPS > 1) ? $clog2(CONV_STEPS) : 1;
  localparam logic [SCORE_W-1:0] MAX_V      = SCORE_W'(MAX_SHOWN);
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(CONV_STEPS - 1);
  localparam logic [6:0]         SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]         SEG_ZERO   = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0]         SEG_T_RST  = SEG_BLANK;
  localparam bit                 LZ_BLANK   = 1'b1;
`else
  localparam logic [6:0]         SEG_T_RST  = SEG_ZERO;
  localparam bit                 LZ_BLANK   = 1'b0;
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] s1_q, s2_q;
  logic [SCORE_W-1:0] shown_q, shown_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [7:0]         bcd_q, bcd_d, bcd_adj;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [3:0]         tens_q, tens_d, ones_q, ones_d;
  logic [6:0]         segt_q, segt_d, sego_q, sego_d;
  logic               busy_q, busy_d, sat_q, sat_d;

  // Two-flop sampler; s1==s2 marks a value that held for a full edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.score;
      s2_q <= s1_q;
    end
  end

  // State, conversion and display registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shown_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      segt_q  <= SEG_T_RST;
      sego_q  <= SEG_ZERO;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      segt_q  <= segt_d;
      sego_q  <= sego_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state: capture in IDLE, add-3/shift in CONV, publish in UPD.
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    segt_d  = segt_q;
    sego_d  = sego_q;
    busy_d  = busy_q;
    sat_d   = sat_q;

    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

    case (state_q)
      IDLE: begin
        if ((s1_q == s2_q) && (s2_q != shown_q)) begin
          bin_d   = (s2_q > MAX_V) ? MAX_V : s2_q;
          bcd_d   = '0;
          step_d  = '0;
          shown_d = s2_q;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        step_d         = step_q + 1'b1;
        if (step_q == LAST_STEP) state_d = UPD;
      end
      UPD: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        segt_d  = (LZ_BLANK && bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
        sego_d  = seg7(bcd_q[3:0]);
        sat_d   = (shown_q > MAX_V);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tens_bcd = tens_q;
  assign bus.ones_bcd = ones_q;
  assign bus.seg_tens = segt_q;
  assign bus.seg_ones = sego_q;
  assign bus.busy     = busy_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display: reset, latency, saturation, wrap,
// mid-conversion changes, skewed input and the tens-blanking option.
module tb_score_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0 = 7'b1111111;
`else
  localparam logic [6:0] T0 = 7'b1000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  score_bcd_display_if bus ();
  score_bcd_display dut (.clk(clk), .rst(rst), .bus(bus));

  // Optionally drive a new score, then time busy rise (edges) and width.
  task automatic run_conv(input logic [6:0] v, input bit drive,
                          output int rise, output int blen, output bit glitch);
    logic [3:0] t0, o0;
    rise = -1; blen = 0; glitch = 1'b0;
    if (drive) begin
      @(negedge clk);
      bus.score = v;
    end
    t0 = bus.tens_bcd; o0 = bus.ones_bcd;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.busy) begin rise = i; break; end
    end
    if (rise > 0) begin
      blen = 1;
      if (bus.tens_bcd !== t0 || bus.ones_bcd !== o0) glitch = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (!bus.busy) break;
        blen++;
        if (bus.tens_bcd !== t0 || bus.ones_bcd !== o0) glitch = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    bus.score = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.busy, bus.sat} !== 10'h0) begin
      bad++; $display("FAIL reset_state got t=%0d o=%0d busy=%b sat=%b exp 0/0/0/0",
                      bus.tens_bcd, bus.ones_bcd, bus.busy, bus.sat);
    end
    total++;
    if ({bus.seg_tens, bus.seg_ones} !== {T0, S0}) begin
      bad++; $display("FAIL reset_seg got %b %b exp %b %b", bus.seg_tens, bus.seg_ones, T0, S0);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int r, b; bit g;
    run_conv(7'd42, 1'b1, r, b, g);
    total++;
    if (r !== 3) begin bad++; $display("FAIL basic_rise got=%0d exp=3", r); end
    total++;
    if (b !== 8) begin bad++; $display("FAIL basic_busy_len got=%0d exp=8", b); end
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.sat} !== {4'd4, 4'd2, 1'b0}) begin
      bad++; $display("FAIL basic_digits got %0d/%0d sat=%b exp 4/2 sat=0",
                      bus.tens_bcd, bus.ones_bcd, bus.sat);
    end
    total++;
    if ({bus.seg_tens, bus.seg_ones} !== {S4, S2}) begin
      bad++; $display("FAIL basic_seg got %b %b exp %b %b", bus.seg_tens, bus.seg_ones, S4, S2);
    end
    total++;
    if (g !== 1'b0) begin bad++; $display("FAIL basic_glitch got=%b exp=0", g); end
  endtask

  task automatic test_reset_midconv();
    int r, b; bit g;
    @(negedge clk);
    bus.score = 7'd57;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) break;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.busy, bus.sat, bus.seg_ones, bus.seg_tens}
        !== {4'd0, 4'd0, 1'b0, 1'b0, S0, T0}) begin
      bad++; $display("FAIL midconv_reset got %0d/%0d busy=%b sat=%b seg=%b %b",
                      bus.tens_bcd, bus.ones_bcd, bus.busy, bus.sat, bus.seg_tens, bus.seg_ones);
    end
    @(negedge clk);
    rst = 1'b1;
    run_conv(7'd57, 1'b0, r, b, g);
    total++;
    if (r !== 3 || b !== 8) begin
      bad++; $display("FAIL midconv_restart got rise=%0d len=%0d exp 3/8", r, b);
    end
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones} !== {4'd5, 4'd7, S5, S7}) begin
      bad++; $display("FAIL midconv_digits got %0d/%0d exp 5/7", bus.tens_bcd, bus.ones_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int r, b, n; bit g;
    @(negedge clk);
    bus.score = 7'd12;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) break;
    end
    @(negedge clk); bus.score = 7'd13;
    @(negedge clk); bus.score = 7'd14;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    total++;
    if ({bus.busy, bus.tens_bcd, bus.ones_bcd} !== {1'b0, 4'd1, 4'd2}) begin
      bad++; $display("FAIL b2b_first got busy=%b %0d/%0d exp 0 1/2",
                      bus.busy, bus.tens_bcd, bus.ones_bcd);
    end
    run_conv(7'd0, 1'b0, r, b, g);
    total++;
    if (r !== 1 || b !== 8) begin
      bad++; $display("FAIL b2b_restart got rise=%0d len=%0d exp 1/8", r, b);
    end
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones} !== {4'd1, 4'd4, S1, S4}) begin
      bad++; $display("FAIL b2b_final got %0d/%0d exp 1/4", bus.tens_bcd, bus.ones_bcd);
    end
    n = 0;
    repeat (15) begin @(negedge clk); if (bus.busy) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL b2b_settled busy_cycles got=%0d exp=0", n); end
  endtask

  task automatic test_skew();
    int r, b, n; bit g;
    run_conv(7'd8, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd} !== {4'd0, 4'd8}) begin
      bad++; $display("FAIL skew_pre got %0d/%0d exp 0/8", bus.tens_bcd, bus.ones_bcd);
    end
    @(negedge clk); bus.score = 7'd15;
    @(negedge clk); bus.score = 7'd16;
    run_conv(7'd0, 1'b0, r, b, g);
    total++;
    if (r !== 3 || b !== 8 || g !== 1'b0) begin
      bad++; $display("FAIL skew_conv got rise=%0d len=%0d glitch=%b exp 3/8/0", r, b, g);
    end
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones} !== {4'd1, 4'd6, S1, S6}) begin
      bad++; $display("FAIL skew_final got %0d/%0d exp 1/6", bus.tens_bcd, bus.ones_bcd);
    end
    n = 0;
    repeat (15) begin @(negedge clk); if (bus.busy) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL skew_settled busy_cycles got=%0d exp=0", n); end
  endtask

  task automatic test_small();
    int r, b; bit g;
    run_conv(7'd7, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones} !== {4'd0, 4'd7, T0, S7}) begin
      bad++; $display("FAIL small7 got %0d/%0d seg=%b %b exp 0/7 seg=%b %b",
                      bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones, T0, S7);
    end
    run_conv(7'd10, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones} !== {4'd1, 4'd0, S1, S0}) begin
      bad++; $display("FAIL small10 got %0d/%0d seg=%b %b exp 1/0",
                      bus.tens_bcd, bus.ones_bcd, bus.seg_tens, bus.seg_ones);
    end
  endtask

  task automatic test_sat();
    int r, b; bit g;
    run_conv(7'd99, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.sat, bus.seg_tens, bus.seg_ones} !== {4'd9, 4'd9, 1'b0, S9, S9}) begin
      bad++; $display("FAIL sat99 got %0d/%0d sat=%b exp 9/9 sat=0", bus.tens_bcd, bus.ones_bcd, bus.sat);
    end
    run_conv(7'd100, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.sat} !== {4'd9, 4'd9, 1'b1}) begin
      bad++; $display("FAIL sat100 got %0d/%0d sat=%b exp 9/9 sat=1", bus.tens_bcd, bus.ones_bcd, bus.sat);
    end
    run_conv(7'd127, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.sat} !== {4'd9, 4'd9, 1'b1} || r !== 3) begin
      bad++; $display("FAIL sat127 got %0d/%0d sat=%b rise=%0d exp 9/9 sat=1 rise=3",
                      bus.tens_bcd, bus.ones_bcd, bus.sat, r);
    end
    run_conv(7'd0, 1'b1, r, b, g);
    total++;
    if ({bus.tens_bcd, bus.ones_bcd, bus.sat, bus.seg_tens, bus.seg_ones} !== {4'd0, 4'd0, 1'b0, T0, S0}) begin
      bad++; $display("FAIL wrap0 got %0d/%0d sat=%b seg=%b %b exp 0/0 sat=0",
                      bus.tens_bcd, bus.ones_bcd, bus.sat, bus.seg_tens, bus.seg_ones);
    end
  endtask

  task automatic test_equal();
    int n;
    n = 0;
    @(negedge clk);
    bus.score = 7'd0;
    repeat (20) begin @(negedge clk); if (bus.busy) n++; end
    total++;
    if (n !== 0 || {bus.tens_bcd, bus.ones_bcd} !== 8'h00) begin
      bad++; $display("FAIL equal_hold got busy_cycles=%0d %0d/%0d exp 0 0/0",
                      n, bus.tens_bcd, bus.ones_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_midconv();
    test_back_to_back();
    test_skew();
    test_small();
    test_sat();
    test_equal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Reader/consumer side of the score path: takes the 7-bit binary score held by the score counter and drives the two seven-segment digits (tens, ones) on the board.
- Score is produced in a separate, flag-clocked domain. The block samples it on the system clock, qualifies stability, and converts it with an iterative shift-add-3 (double-dabble) engine.
- Registered BCD digits and segment patterns are updated only on completed conversions.

Parameters:
- SCORE_W, 7, width of the binary score input.
- MAX_SHOWN, 99, saturation ceiling: any value above it is displayed as MAX_SHOWN.
- CONV_STEPS, 7, number of shift iterations; must equal SCORE_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- score  input  SCORE_W  binary score from the score counter; asynchronous to clk.
- tens_bcd  output  4  registered tens digit, 0..9.
- ones_bcd  output  4  registered ones digit, 0..9.
- seg_tens  output  7  tens segments {g,f,e,d,c,b,a}, active-low.
- seg_ones  output  7  ones segments {g,f,e,d,c,b,a}, active-low.
- busy  output  1  high while a conversion is in flight.
- sat  output  1  high while the displayed value is saturated (last accepted score > MAX_SHOWN).

Behaviour:
- Reset (rst=0, asynchronous, any state, including mid-conversion):
  - State returns to IDLE; all registers clear.
  - tens_bcd=0, ones_bcd=0, busy=0, sat=0.
  - seg_ones=7'b1000000 ("0"); seg_tens=7'b1000000 (see Optional Feature).
  - Sample registers s1/s2 and shown value = 0.
- Input qualification:
  - Every edge: s1<=score, s2<=s1.
  - A candidate is valid only when s1==s2, so one edge of stability is required. This filters multi-bit skew from the foreign domain.
- FSM states: IDLE, CONV, UPD.
- IDLE:
  - If the candidate is valid and s2 != shown: capture v = min(s2, MAX_SHOWN) into the shift register, BCD accumulator <= 0, step <= 0, shown <= s2, busy <= 1, state <= CONV.
  - Capture edge = edge 0.
  - Otherwise hold.
- CONV:
  - Each edge: for each BCD nibble >= 5, add 3. Then shift {bcd, bin} left by one. step <= step+1.
  - After step reaches CONV_STEPS-1 (edge 7), state <= UPD.
- UPD:
  - Edge 8: tens_bcd/ones_bcd and segment outputs load from the accumulator.
  - sat <= (shown > MAX_SHOWN); busy <= 0; state <= IDLE.
- Latency:
  - Outputs change exactly 8 clk edges after the capture edge; busy is high for edges 1..8 inclusive.
  - From a score change to the capture edge is 2–3 edges (synchronizer plus stability).
- Score changes while busy:
  - Not aborted.
  - On return to IDLE the latest stable value is compared against shown and a new conversion starts immediately if it differs.
  - Intermediate values may be skipped; the final value is always displayed.
- Equal value: no conversion, busy stays 0, outputs hold.
- Wrap-around: a score going 127 -> 0 (counter wrap) converts normally to "00", sat=0.
- Segment encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111 (blank; unreachable).
- Outputs never show partial conversion results.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when tens_bcd==0, seg_tens=7'b1111111 (blank). This also applies at reset, so reset shows " 0". tens_bcd itself is still 0.
- Undefined: tens digit always decoded, so reset and scores 0..9 show a leading "0".

Test Plan:
- Reset mid-CONV (assert rst at edge 4 of a conversion of 57) -> immediately busy=0, tens/ones=0/0, seg_ones=1000000; after release with score=57 held, conversion restarts and ends with 5/7.
- score 0->42, held -> busy rises on capture edge; exactly 8 edges later tens=4, ones=2, seg_tens=0011001, seg_ones=0100100, busy=0, sat=0.
- score=99 then 100, then 127 -> display 9/9 with sat=0, then 9/9 with sat=1, then 9/9 with sat=1. Then 127->0 wrap -> 0/0, sat=0.
- Change score 12->13->14 while busy (during conversion of 12) -> first 1/2, then one further conversion ending in 1/4; 1/3 is never required.
- score bits skewed across two edges (8 -> 15 -> 16 transitional) -> only stable values captured; final display 1/6, no glitch values on outputs while busy.
- Build with LEADING_ZERO_BLANK_EN: reset -> seg_tens=1111111; score=7 -> seg_tens blank, seg_ones=1111000; score=10 -> seg_tens=1111001.
